// File: rtl/rv32i_types_pkg.sv
// rv32i_types: shared RV32I types for the MEM stage.
// Provides load/store funct3 width codes and the data-memory access FSM states.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// load_extend: selects the addressed byte/half of a cache word and extends it.
// Ports: rdata (cache word), offset (addr[1:0]), funct3 (load width code),
//        value (sign/zero-extended result; undefined widths pass the word).
module load_extend
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{offset, 3'b000} +: 8];
    assign h = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        value = funct3 == LB  ? {{(XLEN-8){b[7]}}, b}   :
                funct3 == LBU ? {{(XLEN-8){1'b0}}, b}   :
                funct3 == LH  ? {{(XLEN-16){h[15]}}, h} :
                funct3 == LHU ? {{(XLEN-16){1'b0}}, h}  :
                rdata;
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data cache requester with pipeline stall.
// Ports: clk/rst (async active-high); req_valid, mem_read, mem_write, funct3,
//        addr, wdata, pipe_advance from the pipeline; dmem_* cache interface;
//        stall freezes the pipeline; load_data is the extended load result;
//        misalign flags a suppressed misaligned request.
module dmem_access_unit
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            pipe_advance,
    output logic [XLEN-1:0] dmem_address,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [3:0]      dmem_mbe,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);

    dmem_state_t state, next;

    logic            req, wr_sel, is_byte, is_half, mis, start, busy;
    logic [3:0]      mbe_n, mbe_q;
    logic [XLEN-1:0] wdata_n, wdata_q, addr_q, ext;
    logic            rd_q, wr_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    assign req    = req_valid & (mem_read | mem_write);
    // A read wins when both directions are requested.
    assign wr_sel = mem_write & ~mem_read;

    assign is_byte = mem_read ? (funct3 == LB || funct3 == LBU) : (funct3 == SB);
    assign is_half = mem_read ? (funct3 == LH || funct3 == LHU) : (funct3 == SH);
    assign mis     = is_byte ? 1'b0 : is_half ? addr[0] : |addr[1:0];

    assign misalign = ~rst & req & mis;
    assign start    = state == IDLE & req & ~mis;

    assign mbe_n   = mem_read ? 4'b1111 :
                     is_byte  ? 4'b0001 << addr[1:0] :
                     is_half  ? 4'b0011 << {addr[1], 1'b0} :
                     4'b1111;
    assign wdata_n = mem_read ? '0 :
                     is_byte  ? {4{wdata[7:0]}} :
                     is_half  ? {2{wdata[15:0]}} :
                     wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    // DONE absorbs the still-presented instruction until the pipeline advances,
    // so a completed access is never re-issued.
    always_comb begin
        next  = state;
        stall = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next  = BUSY;
                    stall = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_resp)
                    next = DONE;
            end
            DONE: begin
                if (pipe_advance)
                    next = IDLE;
            end
            default: next = IDLE;
        endcase
        if (rst)
            stall = 1'b0;
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .value  (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            mbe_q     <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            load_data <= '0;
        end else begin
            if (start) begin
                addr_q  <= {addr[XLEN-1:2], 2'b00};
                mbe_q   <= mbe_n;
                wdata_q <= wdata_n;
                rd_q    <= mem_read;
                wr_q    <= wr_sel;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
            end
            if (state == BUSY && dmem_resp && rd_q)
                load_data <= ext;
        end
    end

    assign busy         = state == BUSY;
    assign dmem_address = addr_q;
    assign dmem_read    = busy & rd_q;
    assign dmem_write   = busy & wr_q;
    assign dmem_mbe     = busy ? mbe_q : 4'b0000;
    assign dmem_wdata   = busy ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed self-checking bench for dmem_access_unit.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        pipe_advance = 1'b0;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_resp = 1'b0;
    logic        stall;
    logic [31:0] load_data;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .pipe_advance (pipe_advance),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_mbe     (dmem_mbe),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .stall        (stall),
        .load_data    (load_data),
        .misalign     (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic release_req;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // One full aligned transaction; resp arrives in the n-th BUSY cycle.
    task automatic xact(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int n,
                        input logic [31:0] rdat, input logic [31:0] e_addr,
                        input logic [3:0] e_mbe, input logic [31:0] e_wd, input logic [31:0] e_ld);
        pipe_advance = 1'b0;
        present(rd, wr, f3, a, wd);
        #1;
        chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
        chk({tag, "_c0_misalign"}, 32'(misalign), 32'd0);
        chk({tag, "_c0_strobe"}, {30'd0, dmem_read, dmem_write}, 32'd0);
        tick;
        for (int i = 1; i <= n; i++) begin
            chk({tag, "_busy_stall"}, 32'(stall), 32'd1);
            chk({tag, "_busy_read"}, 32'(dmem_read), 32'(rd));
            chk({tag, "_busy_write"}, 32'(dmem_write), 32'(wr & ~rd));
            if (i == 1) begin
                chk({tag, "_address"}, dmem_address, e_addr);
                chk({tag, "_mbe"}, 32'(dmem_mbe), 32'(e_mbe));
                if (!rd)
                    chk({tag, "_wdata"}, dmem_wdata, e_wd);
            end
            if (i == n) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rdat;
            end
            tick;
            dmem_resp  = 1'b0;
            dmem_rdata = 32'd0;
        end
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done_strobe"}, {30'd0, dmem_read, dmem_write}, 32'd0);
        chk({tag, "_done_mbe"}, 32'(dmem_mbe), 32'd0);
        if (rd)
            chk({tag, "_load_data"}, load_data, e_ld);
        pipe_advance = 1'b1;
        tick;
        pipe_advance = 1'b0;
        release_req;
    endtask

    task automatic mis_case(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a);
        present(rd, wr, f3, a, 32'h5555AAAA);
        #1;
        chk({tag, "_misalign"}, 32'(misalign), 32'd1);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick;
            chk({tag, "_no_strobe"}, {30'd0, dmem_read, dmem_write}, 32'd0);
            chk({tag, "_no_stall"}, 32'(stall), 32'd0);
        end
        release_req;
    endtask

    initial begin
        int pulses;
        logic [31:0] held;
        #2;
        chk("reset_read", 32'(dmem_read), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_load_data", load_data, 32'd0);
        chk("reset_address", dmem_address, 32'd0);
        tick;
        rst = 1'b0;
        tick;

        xact("sw", 1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 2, 32'd0,
             32'h100, 4'b1111, 32'hDEADBEEF, 32'd0);
        xact("sb", 1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 1, 32'd0,
             32'h100, 4'b1000, 32'hA5A5A5A5, 32'd0);
        xact("sh", 1'b0, 1'b1, 3'd1, 32'h102, 32'h00001234, 3, 32'd0,
             32'h100, 4'b1100, 32'h12341234, 32'd0);
        xact("lb", 1'b1, 1'b0, 3'd0, 32'h102, 32'd0, 1, 32'h12F03456,
             32'h100, 4'b1111, 32'd0, 32'hFFFFFFF0);
        xact("lbu", 1'b1, 1'b0, 3'd4, 32'h102, 32'd0, 2, 32'h12F03456,
             32'h100, 4'b1111, 32'd0, 32'h000000F0);
        xact("lh", 1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 1, 32'h12F03456,
             32'h100, 4'b1111, 32'd0, 32'h000012F0);
        xact("lhu", 1'b1, 1'b0, 3'd5, 32'h102, 32'd0, 1, 32'h12F03456,
             32'h100, 4'b1111, 32'd0, 32'h000012F0);
        xact("lw", 1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 1, 32'h12F03456,
             32'h100, 4'b1111, 32'd0, 32'h12F03456);
        xact("lh_neg", 1'b1, 1'b0, 3'd1, 32'h302, 32'd0, 1, 32'h80010000,
             32'h300, 4'b1111, 32'd0, 32'hFFFF8001);
        xact("lhu_neg", 1'b1, 1'b0, 3'd5, 32'h302, 32'd0, 1, 32'h80010000,
             32'h300, 4'b1111, 32'd0, 32'h00008001);
        xact("lb_off1", 1'b1, 1'b0, 3'd0, 32'h401, 32'd0, 1, 32'h00007F00,
             32'h400, 4'b1111, 32'd0, 32'h0000007F);
        xact("ld_undef", 1'b1, 1'b0, 3'd7, 32'h104, 32'd0, 1, 32'hCAFEF00D,
             32'h104, 4'b1111, 32'd0, 32'hCAFEF00D);
        xact("rw_both", 1'b1, 1'b1, 3'd2, 32'h200, 32'h11111111, 1, 32'h0BADC0DE,
             32'h200, 4'b1111, 32'd0, 32'h0BADC0DE);

        mis_case("mis_lw", 1'b1, 1'b0, 3'd2, 32'h202);
        mis_case("mis_sh", 1'b0, 1'b1, 3'd1, 32'h101);

        // Completion held in DONE while pipe_advance stays low.
        pulses = 0;
        present(1'b1, 1'b0, 3'd2, 32'h500, 32'd0);
        #1;
        tick;
        if (dmem_read) pulses++;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h76543210;
        tick;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'hFFFFFFFF;
        held = load_data;
        chk("hold_load_data", held, 32'h76543210);
        for (int i = 0; i < 3; i++) begin
            if (dmem_read) pulses++;
            chk("hold_stall", 32'(stall), 32'd0);
            chk("hold_stable", load_data, 32'h76543210);
            tick;
        end
        chk("hold_pulses", 32'(pulses), 32'd1);
        pipe_advance = 1'b1;
        tick;
        pipe_advance = 1'b0;
        present(1'b1, 1'b0, 3'd4, 32'h601, 32'd0);
        #1;
        chk("next_accept_stall", 32'(stall), 32'd1);
        tick;
        chk("next_accept_read", 32'(dmem_read), 32'd1);
        chk("next_accept_addr", dmem_address, 32'h600);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h0000AB00;
        tick;
        dmem_resp = 1'b0;
        chk("next_load_data", load_data, 32'h000000AB);
        pipe_advance = 1'b1;
        tick;
        pipe_advance = 1'b0;
        release_req;
        tick;

        // Reset during BUSY abandons the access immediately.
        present(1'b1, 1'b0, 3'd2, 32'h700, 32'd0);
        tick;
        chk("rst_pre_read", 32'(dmem_read), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_read_drop", 32'(dmem_read), 32'd0);
        chk("rst_stall_drop", 32'(stall), 32'd0);
        release_req;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_after_load_data", load_data, 32'd0);
        chk("rst_after_read", 32'(dmem_read), 32'd0);
        chk("rst_after_stall", 32'(stall), 32'd0);
        present(1'b0, 1'b1, 3'd2, 32'h800, 32'h01020304);
        #1;
        chk("rst_after_accept", 32'(stall), 32'd1);
        tick;
        chk("rst_after_write", 32'(dmem_write), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
